// File: rtl/haar_cascade_engine.sv
// Sequential Haar cascade evaluator for one detection window: walks stage/feature
// ROMs, sums weighted rectangles from an integral image, exits on the first failing stage.
module haar_cascade_engine #(
  parameter int unsigned WIN_W      = 20,
  parameter int unsigned WIN_H      = 20,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_STAGES = 22,
  parameter int unsigned MAX_RECTS  = 3,
  parameter int unsigned FEAT_AW    = 12,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned WGT_W      = 4,
  parameter int unsigned VAL_W      = 24,
  parameter int unsigned ACC_W      = 40
) (
  input  logic                                   CLK,
  input  logic                                   RESET_N,
  input  logic                                   START,
  output logic                                   BUSY,
  output logic                                   DONE,
  output logic                                   IS_FACE,
  output logic [$clog2(NUM_STAGES+1)-1:0]        STAGE_REACHED,
  output logic [$clog2(WIN_W*WIN_H)-1:0]         WIN_ADDR,
  input  logic [DATA_W-1:0]                      WIN_RDATA,
  output logic [$clog2(NUM_STAGES+1)-1:0]        STAGE_ADDR,
  input  logic [CNT_W+VAL_W-1:0]                 STAGE_RDATA,
  output logic [FEAT_AW-1:0]                     FEAT_ADDR,
  input  logic [MAX_RECTS*(4*$clog2(((WIN_W > WIN_H) ? WIN_W : WIN_H)+1)+WGT_W)+3*VAL_W-1:0] FEAT_RDATA
);

  localparam int unsigned CW  = $clog2(((WIN_W > WIN_H) ? WIN_W : WIN_H) + 1);
  localparam int unsigned SW  = $clog2(NUM_STAGES + 1);
  localparam int unsigned WA  = $clog2(WIN_W * WIN_H);
  localparam int unsigned RW  = 4 * CW + WGT_W;
  localparam int unsigned FW  = MAX_RECTS * RW + 3 * VAL_W;
  localparam int unsigned RSW = DATA_W + 2;
  localparam int unsigned PW  = DATA_W + 2 + WGT_W;
  localparam int unsigned RIW = $clog2(MAX_RECTS + 1);

  typedef enum logic [3:0] {
    IDLE, S_FETCH, S_WAIT, F_CHECK, F_FETCH, F_WAIT, R_SEL, CORNER, F_EVAL, S_EVAL, FIN
  } state_e;

  state_e                   state_q, state_d;
  logic                     busy_q, busy_d, done_q, done_d, is_face_q, is_face_d;
  logic [SW-1:0]            stage_reached_q, stage_reached_d;
  logic [WA-1:0]            win_addr_q, win_addr_d;
  logic [SW-1:0]            stage_addr_q, stage_addr_d, stage_idx_q, stage_idx_d;
  logic [FEAT_AW-1:0]       feat_addr_q, feat_addr_d, feat_ptr_q, feat_ptr_d;
  logic [CNT_W-1:0]         feat_cnt_q, feat_cnt_d, feat_num_q, feat_num_d;
  logic signed [VAL_W-1:0]  stage_thr_q, stage_thr_d;
  logic [FW-1:0]            feat_q, feat_d;
  logic [RIW-1:0]           rect_idx_q, rect_idx_d;
  logic [2:0]               corner_q, corner_d;
  logic [CW-1:0]            x2_q, x2_d, y2_q, y2_d, x0_q, x0_d, y0_q, y0_d;
  logic                     has_x0_q, has_x0_d, has_y0_q, has_y0_d;
  logic signed [WGT_W-1:0]  wgt_q, wgt_d;
  logic signed [RSW-1:0]    rsum_q, rsum_d;
  logic signed [ACC_W-1:0]  feat_val_q, feat_val_d, stage_sum_q, stage_sum_d;

  logic [RW-1:0]            cur_rect;
  logic [CW-1:0]            cx, cy, cw, ch;
  logic [WGT_W-1:0]         cwgt;
  logic signed [VAL_W-1:0]  feat_thr, left_val, right_val;
  logic signed [RSW-1:0]    rd, rsum_fin;
  logic signed [PW-1:0]     prod;

  function automatic logic [WA-1:0] lin(input logic [CW-1:0] x, input logic [CW-1:0] y);
    int unsigned t;
    t = 32'(y) * WIN_W + 32'(x);
    return WA'(t);
  endfunction

  // Decode the latched feature record and the rect currently selected
  always_comb begin
    cur_rect = '0;
    for (int i = 0; i < MAX_RECTS; i++) begin
      if (RIW'(i) == rect_idx_q) cur_rect = feat_q[i*RW +: RW];
    end
    cx        = cur_rect[0 +: CW];
    cy        = cur_rect[CW +: CW];
    cw        = cur_rect[2*CW +: CW];
    ch        = cur_rect[3*CW +: CW];
    cwgt      = cur_rect[4*CW +: WGT_W];
    feat_thr  = feat_q[MAX_RECTS*RW +: VAL_W];
    left_val  = feat_q[MAX_RECTS*RW+VAL_W +: VAL_W];
    right_val = feat_q[MAX_RECTS*RW+2*VAL_W +: VAL_W];
    rd        = {2'b00, WIN_RDATA};
  end

  always_comb begin
    state_d         = state_q;
    busy_d          = busy_q;
    done_d          = 1'b0;
    is_face_d       = is_face_q;
    stage_reached_d = stage_reached_q;
    win_addr_d      = win_addr_q;
    stage_addr_d    = stage_addr_q;
    stage_idx_d     = stage_idx_q;
    feat_addr_d     = feat_addr_q;
    feat_ptr_d      = feat_ptr_q;
    feat_cnt_d      = feat_cnt_q;
    feat_num_d      = feat_num_q;
    stage_thr_d     = stage_thr_q;
    feat_d          = feat_q;
    rect_idx_d      = rect_idx_q;
    corner_d        = corner_q;
    x2_d            = x2_q;
    y2_d            = y2_q;
    x0_d            = x0_q;
    y0_d            = y0_q;
    has_x0_d        = has_x0_q;
    has_y0_d        = has_y0_q;
    wgt_d           = wgt_q;
    rsum_d          = rsum_q;
    feat_val_d      = feat_val_q;
    stage_sum_d     = stage_sum_q;
    rsum_fin        = rsum_q;
    prod            = '0;
    case (state_q)
      IDLE: if (START) begin
        state_d         = S_FETCH;
        is_face_d       = 1'b0;
        stage_reached_d = '0;
        stage_idx_d     = '0;
        stage_addr_d    = '0;
        feat_ptr_d      = '0;
      end
      S_FETCH: begin
        stage_sum_d = '0;
        feat_cnt_d  = '0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        feat_num_d  = STAGE_RDATA[0 +: CNT_W];
        stage_thr_d = STAGE_RDATA[CNT_W +: VAL_W];
        state_d     = F_CHECK;
      end
      F_CHECK: begin
        if (feat_cnt_q < feat_num_q) begin
          feat_cnt_d  = feat_cnt_q + CNT_W'(1);
          feat_addr_d = feat_ptr_q;
          feat_ptr_d  = feat_ptr_q + FEAT_AW'(1);
          state_d     = F_FETCH;
        end else begin
          state_d = S_EVAL;
        end
      end
      F_FETCH: begin
        feat_val_d = '0;
        rect_idx_d = '0;
        state_d    = F_WAIT;
      end
      F_WAIT: begin
        feat_d  = FEAT_RDATA;
        state_d = R_SEL;
      end
      // Zero-weight or empty rects are skipped without touching the window buffer
      R_SEL: begin
        if (rect_idx_q == RIW'(MAX_RECTS)) begin
          state_d = F_EVAL;
        end else if (cwgt != '0 && cw != '0 && ch != '0) begin
          x2_d       = cx + cw - CW'(1);
          y2_d       = cy + ch - CW'(1);
          x0_d       = cx - CW'(1);
          y0_d       = cy - CW'(1);
          has_x0_d   = (cx != '0);
          has_y0_d   = (cy != '0);
          wgt_d      = cwgt;
          corner_d   = '0;
          win_addr_d = lin(cx + cw - CW'(1), cy + ch - CW'(1));
          state_d    = CORNER;
        end else begin
          rect_idx_d = rect_idx_q + RIW'(1);
        end
      end
      // Cycle c issues corner c+1 and accumulates corner c-1; missing corners hold the address
      CORNER: begin
        corner_d = corner_q + 3'd1;
        case (corner_q)
          3'd0: if (has_x0_q) win_addr_d = lin(x0_q, y2_q);
          3'd1: if (has_y0_q) win_addr_d = lin(x2_q, y0_q);
          3'd2: if (has_x0_q && has_y0_q) win_addr_d = lin(x0_q, y0_q);
          default: ;
        endcase
        case (corner_q)
          3'd1: rsum_d = rd;
          3'd2: if (has_x0_q) rsum_d = rsum_q - rd;
          3'd3: if (has_y0_q) rsum_d = rsum_q - rd;
          3'd4: begin
            if (has_x0_q && has_y0_q) rsum_fin = rsum_q + rd;
            prod       = rsum_fin * wgt_q;
            feat_val_d = feat_val_q + ACC_W'(prod);
            rect_idx_d = rect_idx_q + RIW'(1);
            state_d    = R_SEL;
          end
          default: ;
        endcase
      end
      F_EVAL: begin
        if (feat_val_q > ACC_W'(feat_thr)) stage_sum_d = stage_sum_q + ACC_W'(right_val);
        else                               stage_sum_d = stage_sum_q + ACC_W'(left_val);
        state_d = F_CHECK;
      end
      S_EVAL: begin
        stage_reached_d = stage_idx_q;
        if (stage_sum_q < ACC_W'(stage_thr_q)) begin
          is_face_d = 1'b0;
          state_d   = FIN;
        end else if (stage_idx_q == SW'(NUM_STAGES - 1)) begin
          is_face_d = 1'b1;
          state_d   = FIN;
        end else begin
          stage_idx_d  = stage_idx_q + SW'(1);
          stage_addr_d = stage_idx_q + SW'(1);
          state_d      = S_FETCH;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) && (state_d != FIN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q         <= IDLE;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      is_face_q       <= 1'b0;
      stage_reached_q <= '0;
      win_addr_q      <= '0;
      stage_addr_q    <= '0;
      stage_idx_q     <= '0;
      feat_addr_q     <= '0;
      feat_ptr_q      <= '0;
      feat_cnt_q      <= '0;
      feat_num_q      <= '0;
      stage_thr_q     <= '0;
      feat_q          <= '0;
      rect_idx_q      <= '0;
      corner_q        <= '0;
      x2_q            <= '0;
      y2_q            <= '0;
      x0_q            <= '0;
      y0_q            <= '0;
      has_x0_q        <= 1'b0;
      has_y0_q        <= 1'b0;
      wgt_q           <= '0;
      rsum_q          <= '0;
      feat_val_q      <= '0;
      stage_sum_q     <= '0;
    end else begin
      state_q         <= state_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      is_face_q       <= is_face_d;
      stage_reached_q <= stage_reached_d;
      win_addr_q      <= win_addr_d;
      stage_addr_q    <= stage_addr_d;
      stage_idx_q     <= stage_idx_d;
      feat_addr_q     <= feat_addr_d;
      feat_ptr_q      <= feat_ptr_d;
      feat_cnt_q      <= feat_cnt_d;
      feat_num_q      <= feat_num_d;
      stage_thr_q     <= stage_thr_d;
      feat_q          <= feat_d;
      rect_idx_q      <= rect_idx_d;
      corner_q        <= corner_d;
      x2_q            <= x2_d;
      y2_q            <= y2_d;
      x0_q            <= x0_d;
      y0_q            <= y0_d;
      has_x0_q        <= has_x0_d;
      has_y0_q        <= has_y0_d;
      wgt_q           <= wgt_d;
      rsum_q          <= rsum_d;
      feat_val_q      <= feat_val_d;
      stage_sum_q     <= stage_sum_d;
    end
  end

  assign BUSY          = busy_q;
  assign DONE          = done_q;
  assign IS_FACE       = is_face_q;
  assign STAGE_REACHED = stage_reached_q;
  assign WIN_ADDR      = win_addr_q;
  assign STAGE_ADDR    = stage_addr_q;
  assign FEAT_ADDR     = feat_addr_q;

endmodule

// File: tb/tb_haar_cascade_engine.sv
// Directed bench for haar_cascade_engine: synchronous ROM models around the DUT,
// integral image I(x,y)=(x+1)(y+1), hand-computed cascade outcomes.
module tb_haar_cascade_engine;

  localparam int unsigned CW = 5;
  localparam int unsigned SW = 5;
  localparam int unsigned WA = 9;
  localparam int unsigned RW = 24;
  localparam int unsigned FW = 144;

  logic            CLK = 1'b0;
  logic            RESET_N = 1'b0;
  logic            START = 1'b0;
  logic            BUSY, DONE, IS_FACE;
  logic [SW-1:0]   STAGE_REACHED, STAGE_ADDR;
  logic [WA-1:0]   WIN_ADDR;
  logic [31:0]     win_rdata;
  logic [31:0]     stage_rdata;
  logic [11:0]     FEAT_ADDR;
  logic [FW-1:0]   feat_rdata;

  logic [31:0]     stage_rom [32];
  logic [FW-1:0]   feat_rom  [64];

  int n_cmp = 0;
  int n_fail = 0;
  int max_stage, max_feat;
  bit bad_win;

  always #5 CLK = ~CLK;

  haar_cascade_engine dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .BUSY(BUSY), .DONE(DONE),
    .IS_FACE(IS_FACE), .STAGE_REACHED(STAGE_REACHED), .WIN_ADDR(WIN_ADDR),
    .WIN_RDATA(win_rdata), .STAGE_ADDR(STAGE_ADDR), .STAGE_RDATA(stage_rdata),
    .FEAT_ADDR(FEAT_ADDR), .FEAT_RDATA(feat_rdata)
  );

  function automatic logic [31:0] integ(input logic [WA-1:0] a);
    int x, y;
    x = int'(a) % 20;
    y = int'(a) / 20;
    return 32'((x + 1) * (y + 1));
  endfunction

  always @(posedge CLK) begin
    win_rdata   <= integ(WIN_ADDR);
    stage_rdata <= stage_rom[STAGE_ADDR];
    feat_rdata  <= (FEAT_ADDR < 12'd64) ? feat_rom[FEAT_ADDR[5:0]] : '0;
  end

  function automatic logic [RW-1:0] rect(input int x, input int y, input int w, input int h, input int wg);
    return {4'(wg), 5'(h), 5'(w), 5'(y), 5'(x)};
  endfunction

  function automatic logic [FW-1:0] feat(input logic [RW-1:0] r0, input logic [RW-1:0] r1,
                                         input logic [RW-1:0] r2, input int thr, input int lv, input int rv);
    return {24'(rv), 24'(lv), 24'(thr), r2, r1, r0};
  endfunction

  function automatic logic [31:0] stg(input int thr, input int cnt);
    return {24'(thr), 8'(cnt)};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_roms();
    for (int i = 0; i < 32; i++) stage_rom[i] = '0;
    for (int i = 0; i < 64; i++) feat_rom[i] = '0;
  endtask

  task automatic clear_mon();
    max_stage = 0;
    max_feat  = 0;
    bad_win   = 1'b0;
  endtask

  // Track peak addresses and any read of the forbidden weight-0/empty rect corners
  task automatic observe();
    if (int'(STAGE_ADDR) > max_stage) max_stage = int'(STAGE_ADDR);
    if (int'(FEAT_ADDR) > max_feat) max_feat = int'(FEAT_ADDR);
    if (WIN_ADDR == 9'd294 || WIN_ADDR == 9'd296 || WIN_ADDR == 9'd334 || WIN_ADDR == 9'd336)
      bad_win = 1'b1;
  endtask

  task automatic wait_done(output int dones);
    dones = 0;
    for (int c = 0; c < 4000 && dones == 0; c++) begin
      observe();
      if (DONE === 1'b1) dones++;
      else @(negedge CLK);
    end
  endtask

  task automatic run_eval(output int dones);
    int extra;
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    wait_done(dones);
    extra = 0;
    repeat (6) begin
      @(negedge CLK);
      observe();
      if (DONE === 1'b1) extra++;
    end
    dones = dones + extra;
  endtask

  task automatic setup_simple(input logic [FW-1:0] f0, input int thr0);
    clear_roms();
    stage_rom[0] = stg(thr0, 1);
    for (int s = 1; s < 22; s++) stage_rom[s] = stg(0, 0);
    feat_rom[0] = f0;
  endtask

  initial begin
    int d;
    clear_roms();
    clear_mon();
    repeat (3) @(negedge CLK);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_face", IS_FACE, 0);
    check("rst_stage", STAGE_REACHED, 0);
    check("rst_addrs", {WIN_ADDR, STAGE_ADDR, FEAT_ADDR}, 0);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLK);

    // Rect (0,0,4,3) w+1: S=12 > 11 -> right 7 >= 7; remaining stages empty and pass
    setup_simple(feat(rect(0, 0, 4, 3, 1), '0, '0, 11, -5, 7), 7);
    run_eval(d);
    check("t1_dones", d, 1);
    check("t1_face", IS_FACE, 1);
    check("t1_stage", STAGE_REACHED, 21);
    check("t1_busy_after", BUSY, 0);

    stage_rom[0] = stg(8, 1);
    run_eval(d);
    check("t1b_dones", d, 1);
    check("t1b_face", IS_FACE, 0);
    check("t1b_stage", STAGE_REACHED, 0);

    // Rect (2,3,5,2) w-2: S=10, value -20 <= 0 -> left -5
    setup_simple(feat(rect(2, 3, 5, 2, -2), '0, '0, 0, -5, 7), -4);
    run_eval(d);
    check("t2_dones", d, 1);
    check("t2_face", IS_FACE, 0);
    check("t2_stage", STAGE_REACHED, 0);
    stage_rom[0] = stg(-5, 1);
    run_eval(d);
    check("t2b_face", IS_FACE, 1);
    check("t2b_stage", STAGE_REACHED, 21);

    // 22 stages x 2 features: 10 (S=9>8) + 1 (12<=20) = 11; stage 4 needs 12
    clear_roms();
    for (int s = 0; s < 22; s++) begin
      stage_rom[s]     = stg((s < 4) ? 11 : ((s == 4) ? 12 : 0), 2);
      feat_rom[2*s]    = feat(rect(0, 2, 3, 3, 1), '0, '0, 8, -10, 10);
      feat_rom[2*s+1]  = feat(rect(1, 1, 2, 2, 3), '0, '0, 20, 1, 50);
    end
    clear_mon();
    run_eval(d);
    check("t3_dones", d, 1);
    check("t3_face", IS_FACE, 0);
    check("t3_stage", STAGE_REACHED, 4);
    check("t3_max_feat", max_feat, 9);
    check("t3_max_stage", max_stage, 4);
    stage_rom[4] = stg(11, 2);
    clear_mon();
    run_eval(d);
    check("t3b_face", IS_FACE, 1);
    check("t3b_stage", STAGE_REACHED, 21);
    check("t3b_max_feat", max_feat, 43);

    // Weight-0 and w=0 slots around a live rect (0,0,4,3) w2 -> 24 > 23 -> right 5
    setup_simple(feat(rect(15, 15, 2, 2, 0), rect(0, 0, 4, 3, 2), rect(15, 15, 0, 2, 5), 23, -1, 5), 5);
    clear_mon();
    run_eval(d);
    check("t4_dones", d, 1);
    check("t4_face", IS_FACE, 1);
    check("t4_stage", STAGE_REACHED, 21);
    check("t4_skip_reads", bad_win, 0);
    stage_rom[1] = stg(1, 0);
    run_eval(d);
    check("t4b_face", IS_FACE, 0);
    check("t4b_stage", STAGE_REACHED, 1);

    // START pulsed again while busy must not queue a second run
    setup_simple(feat(rect(0, 0, 4, 3, 1), '0, '0, 11, -5, 7), 7);
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (5) @(negedge CLK);
    check("t5_busy", BUSY, 1);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    d = 0;
    repeat (300) begin
      @(negedge CLK);
      if (DONE === 1'b1) d++;
    end
    check("t5_dones", d, 1);
    check("t5_face", IS_FACE, 1);

    // START held high: back-to-back runs, results clear at each accept
    START = 1'b1;
    wait_done(d);
    check("t5h_done1", d, 1);
    check("t5h_face1", IS_FACE, 1);
    repeat (2) @(negedge CLK);
    check("t5h_face_clr", IS_FACE, 0);
    check("t5h_stage_clr", STAGE_REACHED, 0);
    check("t5h_busy", BUSY, 1);
    wait_done(d);
    START = 1'b0;
    check("t5h_done2", d, 1);
    check("t5h_face2", IS_FACE, 1);
    d = 0;
    repeat (20) begin
      @(negedge CLK);
      if (DONE === 1'b1) d++;
    end
    check("t5h_no_third", d, 0);

    // Reset during corner reads (cycle 9 after accept is mid-CORNER)
    @(negedge CLK);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    repeat (8) @(negedge CLK);
    check("t6_win_addr_live", WIN_ADDR, 43);
    RESET_N = 1'b0;
    #1;
    check("t6_rst_busy", BUSY, 0);
    check("t6_rst_face", {IS_FACE, STAGE_REACHED}, 0);
    check("t6_rst_addrs", {WIN_ADDR, STAGE_ADDR, FEAT_ADDR}, 0);
    d = 0;
    repeat (3) begin
      @(negedge CLK);
      if (DONE === 1'b1) d++;
    end
    RESET_N = 1'b1;
    repeat (150) begin
      @(negedge CLK);
      if (DONE === 1'b1) d++;
    end
    check("t6_no_done", d, 0);
    run_eval(d);
    check("t6_rerun_dones", d, 1);
    check("t6_rerun_face", IS_FACE, 1);
    check("t6_rerun_stage", STAGE_REACHED, 21);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
